instr_encode: RTL
=================

Name: instr_encode

Overview:
- Inverse of the core's instruction-field decoder.
- Accepts decoded fields (opcode, register indices, func3/func7, full immediate) over a valid/ready handshake. Packs them into 32-bit RV32I instruction words and buffers them in a DEPTH-entry FIFO.
- Feeds an instruction-memory loader or a fetch-side stimulus port, so self-test programs can be generated from field-level descriptions.
- Only the opcode classes the decoder understands are legal: OP-IMM, LUI, OP, LOAD, STORE, BRANCH, JALR.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- opcode  in  7  major opcode.
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- func3  in  3  funct3.
- func7  in  7  funct7.
- imm  in  32  sign-extended immediate, byte offset; for LUI, the full upper value.
- flush  in  1  synchronous FIFO clear.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head word.
- out_instr  out  32  encoded word at the FIFO head.
- err_illegal  out  1  one-cycle pulse when an accepted bundle has an unknown opcode.
- enc_count  out  CNT_W  count of words enqueued.
- ill_count  out  CNT_W  count of illegal bundles.

Behaviour:
- Reset (asynchronous): FIFO empty, pointers 0, count 0. Outputs: out_valid=0, out_instr=0, in_ready=1, err_illegal=0, counters 0. A reset mid-stream discards all queued words.
- Accept condition: in_valid && in_ready. in_ready = !full; there is no combinational dependence on out_ready, so a full FIFO stalls even if a pop happens in the same cycle.
- Pop condition: out_valid && out_ready. out_valid = !empty. out_instr is the head entry, read from registered storage.
- Latency: a word accepted in cycle N is visible on out_valid/out_instr in cycle N+1 when the FIFO was empty.
- Encoding, in all cases the opcode lands in instr[6:0]:
  - OP-IMM 0010011: imm[11:0], rs1, func3, rd. For func3 001 or 101, instr[31:25] is func7 and instr[24:20] is imm[4:0].
  - LOAD 0000011 and JALR 1100111: imm[11:0], rs1, func3, rd.
  - LUI 0110111: imm[31:12], rd. rs1, rs2, func3 and func7 are ignored.
  - OP 0110011: func7, rs2, rs1, func3, rd.
  - STORE 0100011: imm[11:5], rs2, rs1, func3, imm[4:0].
  - BRANCH 1100011: imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11]. imm[0] is ignored.
  - Upper immediate bits not used by the format are ignored; there is no range check.
- Unknown opcode: the bundle is still accepted (handshake completes) but is not enqueued. err_illegal pulses in the cycle after acceptance and ill_count increments.
- Simultaneous push and pop: both pointers advance and the count is unchanged. Push and pop while empty is impossible, since a pop requires out_valid.
- Pointers wrap modulo DEPTH. full/empty are derived from a count register of width log2(DEPTH)+1.
- flush: next cycle the FIFO is empty. flush has priority over a same-cycle push (the push is dropped but counted as accepted) and over a same-cycle pop. Counters are not cleared.
- Counters saturate at all-ones, no wrap. enc_count increments per legal enqueue; ill_count increments per illegal accept.

Optional Feature:
- Macro: INSTR_ENCODE_STATS_EN.
- Defined: enc_count and ill_count are live, as described above.
- Undefined: counter logic is omitted and both ports are tied to 0. err_illegal remains functional.

Test Plan:
- Reset, then push each bundle with out_ready=1; out_instr must show, in order:
  - addi x1,x0,5 (op 0010011, rd 1, rs1 0, f3 0, imm 5) -> 0x00500093
  - add x3,x1,x2 -> 0x002081B3
  - srai x4,x1,3 (f7 0100000, imm 3) -> 0x4030D213
- Push the following; expect the listed words:
  - sw x2,8(x1) -> 0x0020A423
  - bne x1,x2,+8 -> 0x00209463
  - lui x5 with imm 0x12345000 -> 0x123452B7
  - jalr x1,0(x2) -> 0x000100E7
- Backpressure, DEPTH=4, out_ready=0: push 5 bundles -> in_ready drops after the 4th. Raise out_ready -> 4 words exit in order, then the 5th is accepted.
- Opcode 0x7F -> accepted, nothing enqueued, err_illegal high for exactly 1 cycle, ill_count=1. Next legal word is unaffected.
- Simultaneous push and pop at count 2 -> count stays 2 and ordering is preserved. flush with in_valid=1 -> FIFO empty next cycle and the pushed word is lost.
- Assert reset asynchronously mid-stream with 3 words queued -> out_valid=0 immediately, in_ready=1, counters 0.

Source files
------------

// File: rtl/instr_encode.sv
// instr_encode: packs decoded RV32I field bundles (OP-IMM, LUI, OP, LOAD,
// STORE, BRANCH, JALR) into 32-bit instruction words and queues them in a
// DEPTH-entry FIFO for an instruction-memory loader or fetch stimulus port.
// Bundles with an unknown opcode are accepted but dropped, with a one-cycle
// err_illegal pulse.
// Optional feature: define INSTR_ENCODE_STATS_EN to make the saturating
// enc_count / ill_count statistics live; otherwise both ports read 0.
module instr_encode #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic [31:0]      imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err_illegal,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] ill_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_err;

  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_pop;
  logic          w_push;
  logic          w_legal;
  logic [31:0]   w_word;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  // A flush in the same cycle wins over the push: the bundle is consumed but lost.
  assign w_push    = w_accept && w_legal && !flush;

  // The head entry is presented only while valid, so an empty FIFO reads as 0.
  assign out_instr   = out_valid ? r_mem[r_rd_ptr] : 32'h0;
  assign err_illegal = r_err;

  // Field packing per opcode class; unknown opcodes clear w_legal.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs (no latches);
    // combinational logic uses blocking assignments.
    w_legal = 1'b1;
    w_word  = 32'h0;
    case (opcode)
      OPC_OP_IMM: begin
        if (func3 == 3'b001 || func3 == 3'b101)
          w_word = {func7, imm[4:0], rs1, func3, rd, opcode};
        else
          w_word = {imm[11:0], rs1, func3, rd, opcode};
      end
      OPC_LOAD, OPC_JALR:
        w_word = {imm[11:0], rs1, func3, rd, opcode};
      OPC_LUI:
        w_word = {imm[31:12], rd, opcode};
      OPC_OP:
        w_word = {func7, rs2, rs1, func3, rd, opcode};
      OPC_STORE:
        w_word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      OPC_BRANCH:
        w_word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
      default:
        w_legal = 1'b0;
    endcase
  end

  // FIFO storage write.
  // NOTE: the data array has no reset; empty/valid come from r_count, and
  // out_instr is masked while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  // Pointer, occupancy and illegal-pulse state; flush overrides push and pop.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

`ifdef INSTR_ENCODE_STATS_EN
  logic [CNT_W-1:0] r_enc_cnt;
  logic [CNT_W-1:0] r_ill_cnt;

  // Saturating statistics; not cleared by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enc_cnt <= '0;
      r_ill_cnt <= '0;
    end else begin
      if (w_push && r_enc_cnt != '1)
        r_enc_cnt <= r_enc_cnt + CNT_W'(1);
      if (w_accept && !w_legal && r_ill_cnt != '1)
        r_ill_cnt <= r_ill_cnt + CNT_W'(1);
    end
  end

  assign enc_count = r_enc_cnt;
  assign ill_count = r_ill_cnt;
`else
  assign enc_count = '0;
  assign ill_count = '0;
`endif

endmodule
